// File: rtl/dat_mem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs host/loader port, one word access per cycle.
// CPU has fixed priority; a host denied STARVE_LIMIT cycles in a row gets one boosted grant.
module dat_mem_arbiter #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic        host_err,
  output logic [31:0] host_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MAX_ADDR = 32'(DEPTH - 4);
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  typedef enum logic {CPU_PRIO, HOST_BOOST} state_t;

  state_t      state, state_next;
  logic [3:0]  starve_cnt, starve_next;
  logic        cpu_legal, host_legal;
  logic        win_legal, win_we;
  logic [31:0] win_addr, win_wdata;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= MAX_ADDR);
  endfunction

  assign cpu_legal  = is_legal(cpu_addr);
  assign host_legal = is_legal(host_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CPU_PRIO;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // The boost is entered on the same edge the counter reaches the limit, so the
  // host is granted in the very next cycle.
  always_comb begin
    starve_next = starve_cnt;
    if (!host_req || host_gnt)
      starve_next = '0;
    else if (starve_cnt != 4'hF)
      starve_next = starve_cnt + 4'd1;

    state_next = state;
    case (state)
      CPU_PRIO:   if (starve_next >= LIMIT)     state_next = HOST_BOOST;
      HOST_BOOST: if (host_gnt || !host_req)    state_next = CPU_PRIO;
      default:                                  state_next = CPU_PRIO;
    endcase
  end

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    case (state)
      HOST_BOOST: begin
        host_gnt = host_req;
        cpu_gnt  = cpu_req & ~host_req;
      end
      default: begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req & ~cpu_req;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_legal = 1'b0;
    if (cpu_gnt) begin
      win_we    = cpu_we;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
      win_legal = cpu_legal;
    end else if (host_gnt) begin
      win_we    = host_we;
      win_addr  = host_addr;
      win_wdata = host_wdata;
      win_legal = host_legal;
    end
  end

  // Illegal accesses never reach the memory bus.
  always_comb begin
    mem_addr  = win_legal ? win_addr  : '0;
    mem_wdata = win_legal ? win_wdata : '0;
    mem_we    = win_legal &  win_we;
    mem_re    = win_legal & ~win_we;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rvalid  <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt;
      cpu_err     <= cpu_gnt & ~cpu_legal;
      host_rvalid <= host_gnt;
      host_err    <= host_gnt & ~host_legal;
      if (cpu_gnt) begin
        if (!cpu_legal)
          cpu_rdata <= '0;
        else if (!cpu_we)
          cpu_rdata <= mem_rdata;
      end
      if (host_gnt) begin
        if (!host_legal)
          host_rdata <= '0;
        else if (!host_we)
          host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Bench for dat_mem_arbiter: byte-array big-endian memory plus a reference model of
// the arbitration rules, directed scenarios followed by a randomized phase.
module tb_dat_mem_arbiter;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  always #5 clock = ~clock;

  dat_mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_err(host_err),
    .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Environment memory: big-endian bytes, write commits at the edge.
  logic [7:0] mem [DEPTH];
  logic       mem_clr;

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we && mem_addr <= 32'(DEPTH - 4)) begin
      for (int k = 0; k < 4; k++) mem[int'(mem_addr) + k] <= mem_wdata[31 - 8*k -: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_re && mem_addr <= 32'(DEPTH - 4))
      for (int k = 0; k < 4; k++) mem_rdata[31 - 8*k -: 8] = mem[int'(mem_addr) + k];
  end

  // Reference model state
  logic [7:0]  ref_mem [DEPTH];
  int          wait_cnt;
  bit          e_crv, e_cerr, e_hrv, e_herr;
  logic [31:0] e_crd, e_hrd;
  int          n_vec, n_bad;
  bit          skip_comb;
  logic        obs_hg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(DEPTH - 4));
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[31 - 8*k -: 8] = ref_mem[int'(a) + k];
    return w;
  endfunction

  task automatic step(input bit rst,
                      input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit hr, input bit hw, input logic [31:0] ha, input logic [31:0] hd);
    bit boost, cg, hg, any, wl, ww;
    logic [31:0] wa, wd;
    reset = rst;
    cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #3;
    // A host denied LIMIT cycles in a row wins the next contested cycle.
    boost = (wait_cnt >= int'(LIMIT));
    cg  = cr && !(hr && boost);
    hg  = hr && !cg;
    any = cg || hg;
    ww  = cg ? cw : hw;
    wa  = cg ? ca : ha;
    wd  = cg ? cd : hd;
    wl  = any && legal(wa);
    if (!skip_comb) begin
      chk("cpu_gnt",   cpu_gnt,   cg);
      chk("host_gnt",  host_gnt,  hg);
      chk("cpu_stall", cpu_stall, cr && !cg);
      chk("mem_we",    mem_we,    wl && ww);
      chk("mem_re",    mem_re,    wl && !ww);
      if (!any) begin
        chk("mem_addr_idle",  mem_addr,  32'h0);
        chk("mem_wdata_idle", mem_wdata, 32'h0);
      end
      if (wl) chk("mem_addr", mem_addr, wa);
      if (wl && ww) chk("mem_wdata", mem_wdata, wd);
    end
    obs_hg = host_gnt;
    @(posedge clock);
    if (cg) begin
      e_crv = 1; e_cerr = !wl;
      if (!wl) e_crd = '0; else if (!cw) e_crd = ref_word(ca);
    end else begin
      e_crv = 0; e_cerr = 0;
    end
    if (hg) begin
      e_hrv = 1; e_herr = !wl;
      if (!wl) e_hrd = '0; else if (!hw) e_hrd = ref_word(ha);
    end else begin
      e_hrv = 0; e_herr = 0;
    end
    if (wl && ww)
      for (int k = 0; k < 4; k++) ref_mem[int'(wa) + k] = wd[31 - 8*k -: 8];
    wait_cnt = (hr && !hg) ? wait_cnt + 1 : 0;
    if (rst) begin
      e_crv = 0; e_cerr = 0; e_crd = '0;
      e_hrv = 0; e_herr = 0; e_hrd = '0;
      wait_cnt = 0;
    end
    #1;
    chk("cpu_rvalid",  cpu_rvalid,  e_crv);
    chk("cpu_err",     cpu_err,     e_cerr);
    chk("cpu_rdata",   cpu_rdata,   e_crd);
    chk("host_rvalid", host_rvalid, e_hrv);
    chk("host_err",    host_err,    e_herr);
    chk("host_rdata",  host_rdata,  e_hrd);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
    if (r == 1) return ($urandom_range(0, 1) == 0) ? 32'(DEPTH) + 32'(4 * $urandom_range(0, 8))
                                                   : 32'hFFFF_FFFC;
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  initial begin
    int diffs;
    n_vec = 0; n_bad = 0; wait_cnt = 0;
    e_crv = 0; e_cerr = 0; e_crd = '0; e_hrv = 0; e_herr = 0; e_hrd = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    mem_clr = 1; skip_comb = 1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    skip_comb = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_clr = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // CPU store then load, same address
    step(0, 1, 1, 32'd8, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step(0, 1, 0, 32'd8, 32'h0, 0, 0, 0, 0);
    chk("bytes_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Host preload, then host starved by a continuous CPU stream
    step(0, 0, 0, 0, 0, 1, 1, 32'h10, 32'h0102_0304);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 32'(4 * i), 0, 1, 0, 32'h10, 0);
      chk("starve_gnt", obs_hg, (i == 4 || i == 9) ? 1 : 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal accesses: misaligned, out of range, illegal write
    step(0, 1, 0, 32'd6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'd253, 0);
    step(0, 1, 1, 32'h100, 32'h5555_AAAA, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Collision at address 0: CPU reads old data, host write lands later
    step(0, 1, 0, 32'd0, 0, 1, 1, 32'd0, 32'hCAFE_F00D);
    step(0, 0, 0, 0, 0, 1, 1, 32'd0, 32'hCAFE_F00D);
    step(0, 1, 0, 32'd0, 0, 0, 0, 0, 0);

    // Reset right after a CPU read grant
    step(0, 1, 0, 32'd8, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 0);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
